nes_pad_reader: RTL

Sequencer for the NES gamepad serial interface (CD4021 parallel-in/serial-out inside the pad). On a start request it pulses latch, then clocks out NUM_BITS button bits, shifts them into an sipo, and presents them as a registered active-high button vector with a one-cycle valid strobe. It sits between the pad pins and game logic (player movement/fire), and is typically started once per frame from vsync.

---
 rtl/nes_pad_reader_pkg.sv | 19 +
 rtl/register.sv | 21 ++
 rtl/sipo.sv | 24 ++
 rtl/nes_pad_reader.sv | 124 ++++++++++++
 4 files changed

// File: rtl/nes_pad_reader_pkg.sv
// Shared types and phase timing for the NES gamepad sequencer.
package nes_pad_reader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        SETTLE   = 3'd2,
        CLK_LOW  = 3'd3,
        CLK_HIGH = 3'd4
    } state_t;

    localparam int LATCH_MULT = 2;

    // Length in system clocks of each timed state, given half-period d.
    function automatic int phase_len(input state_t s, input int d);
        return (s == LATCH) ? LATCH_MULT * d : d;
    endfunction

endpackage

// File: rtl/register.sv
// Enabled register with parameterised reset value.
module register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sipo.sv
// Serial-in parallel-out shift register; right shift, new bit at MSB.
module sipo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             right,
    input  logic             din,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] q;

    assign q_next = right ? {din, q[WIDTH-1:1]} : q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q <= '0;
        end else if (right) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// NES pad poller: latch pulse, serial clocking, registered button vector.
module nes_pad_reader
    import nes_pad_reader_pkg::*;
#(
    parameter int CLK_DIV  = 300,
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                start,
    input  logic                pad_data,
    output logic                pad_latch,
    output logic                pad_clk,
    output logic [NUM_BITS-1:0] buttons,
    output logic                valid,
    output logic                busy
);

    localparam int TW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(NUM_BITS + 1);

    state_t              state;
    state_t              state_nx;
    logic [TW-1:0]       tick;
    logic [BW-1:0]       bit_cnt;
    logic [1:0]          sync;
    logic                pad_sync;
    logic                phase_done;
    logic                sample;
    logic                done;
    logic [NUM_BITS-1:0] shift_next;

    assign pad_sync = sync[1];
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx   = state;
        sample     = 1'b0;
        done       = 1'b0;
        pad_latch  = 1'b0;
        pad_clk    = 1'b1;
        phase_done = (state != IDLE) &&
                     (tick == TW'(phase_len(state, CLK_DIV) - 1));
        unique case (state)
            IDLE: begin
                if (start) state_nx = LATCH;
            end
            LATCH: begin
                pad_latch = 1'b1;
                if (phase_done) state_nx = SETTLE;
            end
            SETTLE: begin
                if (phase_done) begin
                    sample   = 1'b1;
                    state_nx = CLK_LOW;
                end
            end
            CLK_LOW: begin
                pad_clk = 1'b0;
                if (phase_done) state_nx = CLK_HIGH;
            end
            CLK_HIGH: begin
                if (phase_done) begin
                    sample = 1'b1;
                    if (bit_cnt == BW'(NUM_BITS - 1)) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = CLK_LOW;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            sync    <= 2'b11;
            valid   <= 1'b0;
        end else begin
            state <= state_nx;
            sync  <= {sync[0], pad_data};
            valid <= done;
            if (state == IDLE || phase_done) begin
                tick <= '0;
            end else begin
                tick <= tick + TW'(1);
            end
            // First sample comes at the end of SETTLE, before any pad_clk.
            if (state == SETTLE && phase_done) begin
                bit_cnt <= BW'(1);
            end else if (state == CLK_HIGH && phase_done) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    sipo #(
        .WIDTH(NUM_BITS)
    ) u_sipo (
        .clk   (clk),
        .rst_l (rst_l),
        .right (sample),
        .din   (pad_sync),
        .q_next(shift_next)
    );

    // Pad data is active-low; buttons are presented active-high.
    register #(
        .WIDTH    (NUM_BITS),
        .RESET_VAL('0)
    ) u_buttons (
        .clk  (clk),
        .rst_l(rst_l),
        .en   (done),
        .d    (~shift_next),
        .q    (buttons)
    );

endmodule
